seq_restoring_divider: RTL and testbench
========================================

# seq_restoring_divider

Multi-cycle, parametrised restoring divider that computes one quotient bit per clock. It is the sequential successor to the single-cycle subtract-and-shift divider. It adds signed and unsigned modes, a remainder output, divide-by-zero detection and a start/busy/done handshake, so it can be used as a stalling execute-stage unit in the CPU datapath.

## Interface
Parameters:
- `WIDTH`, 16: operand, quotient and remainder width in bits; must be at least 2.
- `SIGNED_EN`, 1: when 0, the `is_signed` input is ignored and all operations are unsigned.

Ports:
- `clk` input 1: the only clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a division; sampled only in IDLE.
- `is_signed` input 1: two's-complement mode; sampled together with `start`.
- `dividend` input WIDTH: sampled together with `start`.
- `divisor` input WIDTH: sampled together with `start`.
- `busy` output 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` output 1: one-cycle pulse; results are valid in this cycle.
- `quotient` output WIDTH: result register; holds its value until the next `done`.
- `remainder` output WIDTH: result register; holds its value until the next `done`.
- `div_by_zero` output 1: valid with `done`; holds its value until the next `done`.

## Operation
- Reset values: state IDLE; `busy`, `done` and `div_by_zero` = 0; `quotient` and `remainder` = 0; internal registers cleared.
- **IDLE**
  - `start`=1 with nonzero divisor: latch the magnitudes |dividend| and |divisor|, taken as unsigned when the mode is unsigned. Also latch the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)). Clear the partial remainder. Go to RUN with the step counter at WIDTH-1.
  - `start`=1 with divisor 0: go to DONE. Load `quotient` = all ones, `remainder` = raw dividend and `div_by_zero` = 1.
- **RUN** (WIDTH cycles), each cycle:
  - Shift {partial remainder, working dividend} left by 1.
  - Compute a trial subtraction of the divisor magnitude from the partial remainder, using WIDTH+1 bits.
  - If the trial result is non-negative, keep it and shift in quotient bit 1; otherwise restore (keep the shifted value) and shift in 0.
  - At counter 0, go to FIX.
- **FIX** (1 cycle):
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Load `quotient` and `remainder` with the results and clear `div_by_zero`.
  - Go to DONE.
- **DONE** (1 cycle): `done`=1, then return to IDLE.
- Signed semantics:
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 wraps to a quotient of -2^(WIDTH-1) with remainder 0. No flag is raised.
- `start` outside IDLE is ignored; there is no queueing.
- `reset` asserted in any state, including mid-RUN: immediate return to IDLE with all outputs at their reset values, and no `done` for the aborted operation.

## Timing
- Let E0 be the edge that samples `start`.
  - Normal operation: `busy` is high from E0 through the DONE cycle. `done` is high in the cycle after edge E0+WIDTH+1, giving a latency of WIDTH+2 cycles (18 when WIDTH=16).
  - Divide by zero: `done` and the results appear the cycle after E0, a latency of 1 cycle.
- A new `start` is accepted in the cycle after `done`, when the block is back in IDLE. Back-to-back throughput is one operation per WIDTH+3 cycles.
- Outputs are registered. The longest combinational path is the (WIDTH+1)-bit subtract plus the restore mux.

## Structure
- Shared package/header `div_pkg`: state encodings (IDLE, RUN, FIX, DONE) and the divider result-code constants, for reuse by the ALU and hazard unit.
- Sub-module `div_step`: a combinational, WIDTH-parametrised block taking the partial remainder, the incoming dividend bit and the divisor, and producing the next partial remainder and the quotient bit. The top level contains only the FSM, the counter, sign handling and output registers.
- Step-counter width: $clog2(WIDTH).

## Test plan
- Unsigned 0x0F00 / 0x0100 (WIDTH=16) -> `quotient` 0x000F, `remainder` 0x0000, `done` exactly 18 cycles after `start`, `busy` high throughout.
- Unsigned 0xFFFF / 0x0003 -> 0x5555 rem 0x0000. Unsigned 0x0007 / 0x0002 -> 0x0003 rem 0x0001.
- Signed -7 / 2 (0xFFF9 / 0x0002) -> 0xFFFD rem 0xFFFF. Signed 7 / -2 -> 0xFFFD rem 0x0001. Signed 0x8000 / 0xFFFF -> 0x8000 rem 0x0000, `div_by_zero` 0.
- 0x1234 / 0x0000 -> `quotient` 0xFFFF, `remainder` 0x1234, `div_by_zero` 1, `done` 1 cycle after `start`. The next valid divide clears the flag.
- A `start` pulse with different operands at cycle 5 of a running divide -> ignored. The first result is unchanged and `done` pulses exactly once.
- `reset` asserted at RUN cycle 8 -> outputs return to 0 and the block is in IDLE with no `done`. A fresh 0x0064 / 0x000A -> 0x000A rem 0x0000 with normal latency.

Source files
------------

// File: rtl/div_pkg.sv
// Shared divider definitions: FSM state encoding and result codes, also consumed
// by the ALU and hazard unit.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  localparam logic [1:0] DIV_RC_OK   = 2'd0;
  localparam logic [1:0] DIV_RC_ZERO = 2'd1;

  // Result code as seen by downstream units, derived from the divide-by-zero flag.
  function automatic logic [1:0] div_result_code(input logic dbz);
    return dbz ? DIV_RC_ZERO : DIV_RC_OK;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in one dividend bit, trial-subtract the
// divisor, and keep or restore the partial remainder.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  // The partial remainder is always below the divisor, so the shifted value fits
  // in WIDTH+1 bits and the MSB of the difference is a reliable borrow/sign.
  assign w_shifted = {i_rem, i_bit};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  assign o_qbit    = ~w_diff[WIDTH];
  assign o_rem     = o_qbit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider (one quotient bit per clock) with signed/unsigned
// modes, remainder output, divide-by-zero detection and start/busy/done handshake.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  // Handshake: start is sampled only in IDLE; busy rises the cycle after an
  // accepted start and stays high through the single-cycle done pulse; results
  // are valid with done and held until the next done. start while busy is dropped.

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rmd;
  logic             r_dbz;

  logic             w_signed;
  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH-1:0] w_next_rem;
  logic             w_qbit;

  assign w_signed  = SIGNED_EN && is_signed;
  assign w_dvd_neg = w_signed & dividend[WIDTH-1];
  assign w_dsr_neg = w_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dsr_mag = w_dsr_neg ? -divisor  : divisor;

  // The working dividend doubles as the quotient shift register: its MSB feeds
  // the step while quotient bits enter at the LSB.
  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_dsr),
    .o_rem     (w_next_rem),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rmd   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (divisor == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_rmd   <= dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_cnt   <= LAST_STEP;
              r_rem   <= '0;
              r_dvd   <= w_dvd_mag;
              r_dsr   <= w_dsr_mag;
              r_q_neg <= w_dvd_neg ^ w_dsr_neg;
              r_r_neg <= w_dvd_neg;
            end
          end
        end
        ST_RUN: begin
          r_rem <= w_next_rem;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_FIX: begin
          // Most-negative / -1 wraps naturally here: the magnitude 2^(W-1) negates to itself.
          r_quot  <= r_q_neg ? -r_dvd : r_dvd;
          r_rmd   <= r_r_neg ? -r_rem : r_rem;
          r_dbz   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rmd;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider at WIDTH=16.
module tb_seq_restoring_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  seq_restoring_divider #(
    .WIDTH(16),
    .SIGNED_EN(1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Issue one divide and wait for done. lat counts rising edges from the sampling
  // edge to the edge after which done is seen; busy_ok records busy high throughout.
  // Returns one edge after done so the block is back in IDLE.
  task automatic do_div(input logic [15:0] a, input logic [15:0] b, input logic sg,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    start = 1'b1; is_signed = sg; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero});
    end
    checks++;
    if ({quotient, remainder} !== 32'h0) begin
      failures++; $display("FAIL reset_results got=%h exp=00000000", {quotient, remainder});
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [15:0] va [3] = '{16'h0F00, 16'hFFFF, 16'h0007};
    logic [15:0] vb [3] = '{16'h0100, 16'h0003, 16'h0002};
    logic [15:0] eq [3] = '{16'h000F, 16'h5555, 16'h0003};
    logic [15:0] er [3] = '{16'h0000, 16'h0000, 16'h0001};
    int lat;
    logic bok;
    for (int i = 0; i < 3; i++) begin
      do_div(va[i], vb[i], 1'b0, lat, bok);
      checks++;
      if (quotient !== eq[i] || remainder !== er[i]) begin
        failures++;
        $display("FAIL unsigned_%0d got=%h r %h exp=%h r %h", i, quotient, remainder, eq[i], er[i]);
      end
      checks++;
      if (lat !== 18) begin
        failures++; $display("FAIL unsigned_latency_%0d got=%0d exp=18", i, lat);
      end
      checks++;
      if (bok !== 1'b1 || div_by_zero !== 1'b0) begin
        failures++; $display("FAIL unsigned_busy_dbz_%0d got=%b%b exp=10", i, bok, div_by_zero);
      end
    end
    // Same bits as the signed overflow case, but unsigned: 32768 / 65535 = 0 rem 32768.
    do_div(16'h8000, 16'hFFFF, 1'b0, lat, bok);
    checks++;
    if (quotient !== 16'h0000 || remainder !== 16'h8000) begin
      failures++; $display("FAIL unsigned_8000_ffff got=%h r %h exp=0000 r 8000", quotient, remainder);
    end
  endtask

  task automatic test_signed();
    logic [15:0] va [4] = '{16'hFFF9, 16'h0007, 16'h8000, 16'hFFF9};
    logic [15:0] vb [4] = '{16'h0002, 16'hFFFE, 16'hFFFF, 16'hFFFE};
    logic [15:0] eq [4] = '{16'hFFFD, 16'hFFFD, 16'h8000, 16'h0003};
    logic [15:0] er [4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF};
    int lat;
    logic bok;
    for (int i = 0; i < 4; i++) begin
      do_div(va[i], vb[i], 1'b1, lat, bok);
      checks++;
      if (quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL signed_%0d got=%h r %h z %b exp=%h r %h z 0", i, quotient, remainder,
                 div_by_zero, eq[i], er[i]);
      end
      checks++;
      if (lat !== 18) begin
        failures++; $display("FAIL signed_latency_%0d got=%0d exp=18", i, lat);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic bok;
    do_div(16'h1234, 16'h0000, 1'b0, lat, bok);
    checks++;
    if (quotient !== 16'hFFFF || remainder !== 16'h1234 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL div_zero got=%h r %h z %b exp=ffff r 1234 z 1", quotient, remainder, div_by_zero);
    end
    checks++;
    if (lat !== 1 || bok !== 1'b1) begin
      failures++; $display("FAIL div_zero_latency got=%0d busy=%b exp=1 busy=1", lat, bok);
    end
    do_div(16'h0009, 16'h0003, 1'b0, lat, bok);
    checks++;
    if (div_by_zero !== 1'b0 || quotient !== 16'h0003 || remainder !== 16'h0000) begin
      failures++;
      $display("FAIL div_zero_clear got=%h r %h z %b exp=0003 r 0000 z 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_ignored();
    int n_done = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 16'h0F00; divisor = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 16'h0064; divisor = 16'h0007;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        checks++;
        if (quotient !== 16'h000F || remainder !== 16'h0000) begin
          failures++;
          $display("FAIL ignored_start_result got=%h r %h exp=000f r 0000", quotient, remainder);
        end
      end
    end
    checks++;
    if (n_done !== 1) begin
      failures++; $display("FAIL ignored_start_done_count got=%0d exp=1", n_done);
    end
  endtask

  task automatic test_reset_mid_run();
    int n_done = 0;
    int lat;
    logic bok;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 16'hFFFF; divisor = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 35'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_run got=%b%b%b %h %h st=%0d exp=all zero", busy, done, div_by_zero,
               quotient, remainder, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      failures++; $display("FAIL reset_mid_run_no_done got=%0d exp=0", n_done);
    end
    do_div(16'h0064, 16'h000A, 1'b0, lat, bok);
    checks++;
    if (quotient !== 16'h000A || remainder !== 16'h0000 || lat !== 18) begin
      failures++;
      $display("FAIL after_reset got=%h r %h lat %0d exp=000a r 0000 lat 18", quotient, remainder, lat);
    end
  endtask

  task automatic test_back_to_back();
    int t = 0;
    int first = -1;
    int second = -1;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 16'h0064; divisor = 16'h000A;
    while (second < 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
      if (done) begin
        if (first < 0) first = t;
        else second = t;
      end
    end
    start = 1'b0;
    checks++;
    if (second - first !== 19) begin
      failures++; $display("FAIL back_to_back_period got=%0d exp=19", second - first);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
